iter_divider: RTL

Parametrised multi-cycle radix-2 integer divider for the EXE stage. It replaces the vendor signed/unsigned divider IP pair with one in-house unit. It accepts one signed or unsigned division per valid/ready handshake and produces quotient and remainder together after a fixed latency. It supports pipeline flush and output back-pressure, and passes an opaque tag through so the EXE stage can match results to instructions.

---
 rtl/iter_divider_pkg.sv | 33 +++
 rtl/iter_divider_if.sv | 27 ++
 rtl/iter_divider.sv | 132 +++++++++++++
 3 files changed

// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared CPU definitions for the divider FSM and mul/div op decode
package iter_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Mul/div op encoding seen by decode; DIV/MOD variants drive iter_divider.
    localparam logic [2:0] MD_OP_MUL   = 3'd0;
    localparam logic [2:0] MD_OP_MULH  = 3'd1;
    localparam logic [2:0] MD_OP_MULHU = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_DIVU  = 3'd4;
    localparam logic [2:0] MD_OP_MOD   = 3'd5;
    localparam logic [2:0] MD_OP_MODU  = 3'd6;

    function automatic logic md_op_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_MOD);
    endfunction

    function automatic logic md_op_is_div(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU) ||
               (op == MD_OP_MOD) || (op == MD_OP_MODU);
    endfunction

    function automatic logic md_op_wants_rem(input logic [2:0] op);
        return (op == MD_OP_MOD) || (op == MD_OP_MODU);
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/response handshake bundle between EXE stage and divider
interface iter_divider_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
        input  in_ready, out_valid, out_quot, out_rem, out_tag
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
        output in_ready, out_valid, out_quot, out_rem, out_tag
    );
endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle radix-2 restoring divider, signed/unsigned, with flush and tag
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    iter_divider_if.slave div,
    output logic          busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = DIV_IDLE;
    localparam logic [1:0] S_CALC = DIV_CALC;
    localparam logic [1:0] S_FIX  = DIV_FIX;
    localparam logic [1:0] S_DONE = DIV_DONE;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] out_quot_q;
    logic [WIDTH-1:0] out_rem_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             quot_neg_q;
    logic             rem_neg_q;
    logic             div_zero_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    always_comb begin
        a_neg   = div.in_signed & div.in_dividend[WIDTH-1];
        b_neg   = div.in_signed & div.in_divisor[WIDTH-1];
        a_mag   = a_neg ? negate(div.in_dividend) : div.in_dividend;
        b_mag   = b_neg ? negate(div.in_divisor) : div.in_divisor;
        shifted = {rem_q, quot_q[WIDTH-1]};
        // shifted < 2*divisor, so bit WIDTH of the difference is exactly the borrow
        trial   = shifted - {1'b0, divisor_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            out_quot_q <= '0;
            out_rem_q  <= '0;
            tag_q      <= '0;
            out_tag_q  <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div.in_valid) begin
                        quot_q     <= a_mag;
                        divisor_q  <= b_mag;
                        rem_q      <= '0;
                        dividend_q <= div.in_dividend;
                        quot_neg_q <= a_neg ^ b_neg;
                        rem_neg_q  <= a_neg;
                        div_zero_q <= (div.in_divisor == '0);
                        tag_q      <= div.in_tag;
                        count      <= CNT_W'(WIDTH - 1);
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (trial[WIDTH]) begin
                        rem_q  <= shifted[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_q  <= trial[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
                    end
                    if (count == '0) begin
                        state <= S_FIX;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (div_zero_q) begin
                        out_quot_q <= '1;
                        out_rem_q  <= dividend_q;
                    end else begin
                        out_quot_q <= quot_neg_q ? negate(quot_q) : quot_q;
                        out_rem_q  <= rem_neg_q ? negate(rem_q) : rem_q;
                    end
                    out_tag_q <= tag_q;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (div.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign div.in_ready  = (state == S_IDLE);
    assign div.out_valid = (state == S_DONE);
    assign busy          = (state != S_IDLE);
    assign div.out_quot  = out_quot_q;
    assign div.out_rem   = out_rem_q;
    assign div.out_tag   = out_tag_q;

endmodule
